// File: rtl/dm_mem_host.sv
// Instruction/data BRAM owner for the datamover; host load/dump port; single-run launch and monitor.
// Latency: fetch, data and host reads are 1 cycle; start -> inst_val 1 cycle; done 1 cycle after completion.
// Backpressure: none; host accesses outside IDLE are dropped and flagged by a host_reject pulse.
module dm_mem_host #(
  parameter int          AWIDTH  = 8,
  parameter int          IAWIDTH = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    host_sel,
  input  logic [13:0]             host_addr,
  input  logic                    host_we,
  input  logic                    host_re,
  input  logic [31:0]             host_wdata,
  output logic [31:0]             host_rdata,
  output logic                    host_rvalid,
  output logic                    host_reject,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  output logic [31:0]             run_cycles,
  input  logic [IAWIDTH-1:0]      iaddr,
  output logic [4+2*AWIDTH-1:0]   inst,
  output logic                    inst_val,
  input  logic [AWIDTH-1:0]       daddr,
  input  logic                    denb,
  input  logic                    dwenb,
  input  logic [31:0]             dout,
  output logic [31:0]             din,
  input  logic                    data_rdy
);

  localparam int          IW  = 4 + 2 * AWIDTH;
  localparam logic [31:0] TMO = 32'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic [31:0]        r_cnt;
  logic [IW-1:0]      r_ibram [2**IAWIDTH];
  logic [31:0]        r_dbram [2**AWIDTH];

  logic               w_idle;
  logic               w_host_wr;
  logic               w_host_rd;
  logic               w_dm_wr;
  logic               w_dm_rd;
  logic [31:0]        w_cnt_inc;
  logic [AWIDTH-1:0]  w_had;
  logic [IAWIDTH-1:0] w_hai;
  logic               w_unused;

  // Host port is only live while idle; datamover port only while a run is in flight,
  // so the two never contend for the data BRAM write port.
  assign w_idle    = (r_state == S_IDLE);
  assign w_host_wr = w_idle & host_we;
  assign w_host_rd = w_idle & host_re & ~host_we;
  assign w_dm_wr   = busy & denb & dwenb;
  assign w_dm_rd   = busy & denb & ~dwenb;
  assign w_cnt_inc = r_cnt + 32'd1;
  assign w_had     = host_addr[AWIDTH-1:0];
  assign w_hai     = host_addr[IAWIDTH-1:0];
  assign w_unused  = ^host_addr;

  // Memory arrays: not reset, and writes are blocked while reset is asserted so contents survive it.
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (w_host_wr && !host_sel) begin
        r_dbram[w_had] <= host_wdata;
      end else if (w_dm_wr) begin
        r_dbram[daddr] <= dout;
      end
      if (w_host_wr && host_sel) begin
        r_ibram[w_hai] <= host_wdata[IW-1:0];
      end
    end
  end

  // Registered read paths: instruction fetch, datamover data (write-through), host read and reject.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      inst        <= '0;
      din         <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      host_reject <= 1'b0;
    end else begin
      inst <= r_ibram[iaddr];
      if (w_dm_wr) begin
        din <= dout;
      end else if (w_dm_rd) begin
        din <= r_dbram[daddr];
      end
      host_rvalid <= w_host_rd;
      host_reject <= ~w_idle & (host_we | host_re);
      if (w_host_rd) begin
        host_rdata <= host_sel ? 32'(r_ibram[w_hai]) : r_dbram[w_had];
      end
    end
  end

  // Run control FSM; status outputs are set on the transition into the state they describe.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      busy       <= 1'b0;
      inst_val   <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      run_cycles <= '0;
    end else begin
      inst_val <= 1'b0;
      done     <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_ARM;
            inst_val   <= 1'b1;
            busy       <= 1'b1;
            r_cnt      <= '0;
            timeout    <= 1'b0;
            run_cycles <= '0;
          end
        end
        S_ARM: begin
          r_state <= S_RUN;
        end
        S_RUN: begin
          // Completion on the TIMEOUT-th cycle counts as success, so data_rdy is checked first.
          if (data_rdy) begin
            r_state    <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            timeout    <= 1'b0;
            run_cycles <= w_cnt_inc;
          end else if (w_cnt_inc == TMO) begin
            r_state    <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            timeout    <= 1'b1;
            run_cycles <= TMO;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_mem_host.sv
module tb_dm_mem_host;

  localparam int AW  = 8;
  localparam int IAW = 8;
  localparam int TMO = 16;
  localparam int IW  = 4 + 2 * AW;

  logic           clk = 1'b0;
  logic           rstn;
  logic           host_sel;
  logic [13:0]    host_addr;
  logic           host_we;
  logic           host_re;
  logic [31:0]    host_wdata;
  logic [31:0]    host_rdata;
  logic           host_rvalid;
  logic           host_reject;
  logic           start;
  logic           busy;
  logic           done;
  logic           timeout;
  logic [31:0]    run_cycles;
  logic [IAW-1:0] iaddr;
  logic [IW-1:0]  inst;
  logic           inst_val;
  logic [AW-1:0]  daddr;
  logic           denb;
  logic           dwenb;
  logic [31:0]    dout;
  logic [31:0]    din;
  logic           data_rdy;

  always #5 clk = ~clk;

  dm_mem_host #(.AWIDTH(AW), .IAWIDTH(IAW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .host_sel(host_sel), .host_addr(host_addr), .host_we(host_we), .host_re(host_re),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .host_reject(host_reject),
    .start(start), .busy(busy), .done(done), .timeout(timeout), .run_cycles(run_cycles),
    .iaddr(iaddr), .inst(inst), .inst_val(inst_val),
    .daddr(daddr), .denb(denb), .dwenb(dwenb), .dout(dout), .din(din), .data_rdy(data_rdy)
  );

  // Reference state: memory images and the value din is expected to hold.
  logic [31:0]   m_d [32];
  logic [IW-1:0] m_i [16];
  logic [31:0]   exp_din;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic hwrite(input logic sel, input int a, input logic [31:0] d);
    host_sel   = sel;
    host_addr  = 14'(a);
    host_wdata = d;
    host_we    = 1'b1;
    cyc();
    host_we = 1'b0;
    if (sel) m_i[a] = d[IW-1:0];
    else     m_d[a] = d;
    chk("hwr_reject", host_reject, 32'd0);
    chk("hwr_rvalid", host_rvalid, 32'd0);
  endtask

  task automatic hread(input logic sel, input int a, input string tag);
    host_sel  = sel;
    host_addr = 14'(a);
    host_re   = 1'b1;
    cyc();
    host_re = 1'b0;
    chk($sformatf("%s_rvalid", tag), host_rvalid, 32'd1);
    chk($sformatf("%s_rdata@%0d", tag, a), host_rdata, sel ? 32'(m_i[a]) : m_d[a]);
  endtask

  // One program run: data_rdy raised on RUN cycle k (k > TMO means never).
  // directed: cycle 1 writes DEADBEEF to 0x10 from the datamover, cycle 2 tries a host write of CAFE to dbram[5].
  task automatic run_prog(input int k, input bit directed, input int ia);
    int          n;
    bit          to;
    int          ha;
    logic [31:0] hv;
    n  = (k <= TMO) ? k : TMO;
    to = (k > TMO);
    iaddr = IAW'(ia);
    // A host write issued alongside start is still performed.
    ha = 24 + $urandom_range(0, 7);
    hv = $urandom;
    host_sel = 1'b0; host_addr = 14'(ha); host_wdata = hv; host_we = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0; host_we = 1'b0;
    m_d[ha] = hv;
    chk("arm_inst_val", inst_val, 32'd1);
    chk("arm_busy", busy, 32'd1);
    chk("arm_done", done, 32'd0);
    chk("arm_reject", host_reject, 32'd0);
    chk("arm_inst", inst, m_i[ia]);
    cyc();
    chk("run_inst_val", inst_val, 32'd0);
    chk("run_busy", busy, 32'd1);
    for (int c = 1; c <= n; c++) begin
      int          op;
      int          a;
      logic [31:0] v;
      bit          hacc;
      a  = $urandom_range(0, 31);
      v  = $urandom;
      op = directed ? ((c == 1) ? 1 : 0) : int'($urandom_range(0, 2));
      if (directed && c == 1) begin
        a = 16;
        v = 32'hDEADBEEF;
      end
      hacc = directed ? (c == 2) : ($urandom_range(0, 3) == 0);
      data_rdy = (c == k);
      start    = $urandom_range(0, 1);
      denb  = (op != 0);
      dwenb = (op == 1);
      daddr = AW'(a);
      dout  = v;
      if (hacc) begin
        host_sel   = 1'b0;
        host_addr  = directed ? 14'd5 : 14'($urandom_range(0, 31));
        host_wdata = directed ? 32'h0000CAFE : $urandom;
        host_we    = 1'b1;
      end
      cyc();
      denb = 1'b0; dwenb = 1'b0; host_we = 1'b0; data_rdy = 1'b0; start = 1'b0;
      if (op == 1) begin
        m_d[a]  = v;
        exp_din = v;
      end else if (op == 2) begin
        exp_din = m_d[a];
      end
      chk($sformatf("run_din_c%0d", c), din, exp_din);
      chk($sformatf("run_reject_c%0d", c), host_reject, 32'(hacc));
      chk("run_inst", inst, m_i[ia]);
      if (c < n) begin
        chk($sformatf("run_busy_c%0d", c), busy, 32'd1);
        chk($sformatf("run_done_c%0d", c), done, 32'd0);
      end
    end
    chk("done_pulse", done, 32'd1);
    chk("done_busy", busy, 32'd0);
    chk("done_timeout", timeout, 32'(to));
    chk("done_run_cycles", run_cycles, 32'(n));
    chk("done_inst_val", inst_val, 32'd0);
    cyc();
    chk("post_done", done, 32'd0);
    chk("post_busy", busy, 32'd0);
    chk("post_timeout", timeout, 32'(to));
    chk("post_run_cycles", run_cycles, 32'(n));
    chk("post_reject", host_reject, 32'd0);
  endtask

  initial begin
    rstn = 1'b0; host_sel = 1'b0; host_addr = '0; host_we = 1'b0; host_re = 1'b0;
    host_wdata = '0; start = 1'b0; iaddr = '0; daddr = '0; denb = 1'b0; dwenb = 1'b0;
    dout = '0; data_rdy = 1'b0;
    exp_din = '0;
    cyc();
    cyc();
    // Reset state
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_timeout", timeout, 32'd0);
    chk("rst_run_cycles", run_cycles, 32'd0);
    chk("rst_inst_val", inst_val, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_din", din, 32'd0);
    chk("rst_rdata", host_rdata, 32'd0);
    chk("rst_rvalid", host_rvalid, 32'd0);
    chk("rst_reject", host_reject, 32'd0);
    rstn = 1'b1;
    cyc();

    // Host load of both memories
    hwrite(1'b0, 0, 32'h11111111);
    hwrite(1'b0, 1, 32'h22222222);
    hwrite(1'b0, 2, 32'h33333333);
    hwrite(1'b0, 3, 32'h44444444);
    for (int i = 4; i < 32; i++) hwrite(1'b0, i, $urandom);
    hwrite(1'b1, 0, 32'h00010203);
    for (int i = 1; i < 16; i++) hwrite(1'b1, i, $urandom);
    hread(1'b0, 2, "t1_read");
    chk("t1_const", host_rdata, 32'h33333333);
    cyc();
    chk("t1_rvalid_pulse", host_rvalid, 32'd0);

    // Random host traffic while idle, plus fetch port checks
    for (int i = 0; i < 30; i++) begin
      int a;
      bit sel;
      sel = $urandom_range(0, 1);
      a   = sel ? $urandom_range(0, 15) : $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) hwrite(sel, a, $urandom);
      else                           hread(sel, a, "rnd_read");
      iaddr = IAW'($urandom_range(0, 15));
      cyc();
      chk("fetch", inst, m_i[int'(iaddr)]);
    end
    // Both strobes: the write wins, no rvalid
    host_sel = 1'b0; host_addr = 14'd9; host_wdata = 32'h0BADF00D; host_we = 1'b1; host_re = 1'b1;
    cyc();
    host_we = 1'b0; host_re = 1'b0;
    m_d[9] = 32'h0BADF00D;
    chk("we_wins_rvalid", host_rvalid, 32'd0);
    hread(1'b0, 9, "we_wins");

    // Datamover port ignored while idle
    denb = 1'b1; dwenb = 1'b1; daddr = 8'd3; dout = 32'hFFFF0000;
    cyc();
    denb = 1'b0; dwenb = 1'b0;
    chk("idle_din_hold", din, exp_din);
    hread(1'b0, 3, "idle_dm_ignored");

    // Run with completion on the 5th RUN cycle, fetching ibram[0]
    run_prog(5, 1'b0, 0);
    // Directed write-through and rejected host write during a run
    run_prog(7, 1'b1, 2);
    hread(1'b0, 16, "t3_read");
    chk("t3_const", host_rdata, 32'hDEADBEEF);
    hread(1'b0, 5, "t5_unchanged");
    // Timeout run, then the boundary cases around TIMEOUT
    run_prog(100, 1'b0, 3);
    run_prog(1, 1'b0, 4);
    run_prog(TMO, 1'b0, 5);
    run_prog(TMO + 1, 1'b0, 6);
    for (int i = 0; i < 6; i++) run_prog($urandom_range(1, TMO + 4), 1'b0, $urandom_range(0, 15));

    // Reset in the middle of a run
    iaddr = 8'd1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    denb = 1'b1; dwenb = 1'b1; daddr = 8'd20; dout = 32'h5A5A1234;
    cyc();
    denb = 1'b0; dwenb = 1'b0;
    m_d[20] = 32'h5A5A1234;
    exp_din = 32'h5A5A1234;
    chk("t6_din", din, exp_din);
    cyc();
    cyc();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    exp_din = '0;
    chk("t6_busy", busy, 32'd0);
    chk("t6_inst_val", inst_val, 32'd0);
    chk("t6_done", done, 32'd0);
    chk("t6_din_rst", din, 32'd0);
    chk("t6_run_cycles", run_cycles, 32'd0);
    for (int i = 0; i < TMO + 4; i++) begin
      cyc();
      chk("t6_no_done", done, 32'd0);
      chk("t6_idle_busy", busy, 32'd0);
    end
    hread(1'b0, 20, "t6_kept");

    // Final dump of both memories against the model
    for (int i = 0; i < 32; i++) hread(1'b0, i, "dump_d");
    for (int i = 0; i < 16; i++) hread(1'b1, i, "dump_i");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
